ram_2port_bist: RTL and testbench
=================================

# ram_2port_bist

Parametrised self-checking dual-port RAM block: an inferred simple dual-port RAM plus a write/read-back controller that fills the RAM with a selectable data pattern, reads it back, and compares every word against the regenerated expected value. It sits as a stand-alone test/bring-up block on the board clock. It is the generalised successor of the fixed 8-bit x 32 write-then-read RAM demo, with configurable width and depth, several patterns, a fault-injection mode, error counting and a start/done handshake. RAM-side signals are exported for logic-analyser capture.

## Interface
- DATA_W, 8: RAM word width, 2..32.
- ADDR_W, 5: RAM address width.
- DEPTH, 32: number of words tested, 2..2^ADDR_W.

- sys_clk  in  1  single clock for RAM and controller.
- sys_rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle run request; ignored while busy.
- mode  in  2  pattern select, latched on accepted start.
- seed  in  DATA_W  pattern seed, latched on accepted start.
- busy  out  1  high from the cycle after an accepted start through the last compare.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  err_cnt==0 at end of run; valid from done until next accepted start.
- err_cnt  out  16  mismatch count, saturating at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of first mismatch; 0 if none.
- ram_wr_en, ram_wr_addr[ADDR_W], ram_wr_data[DATA_W]  out  RAM write port, debug copy.
- ram_rd_en, ram_rd_addr[ADDR_W], ram_rd_data[DATA_W]  out  RAM read port, debug copy.

## Operation
- FSM states: IDLE -> WRITE -> READ -> DRAIN -> FIN -> IDLE.
- IDLE: start=1 latches mode and seed, clears err_cnt, first_err_addr and pass, and moves to WRITE.
- WRITE: ram_wr_en=1; ram_wr_addr steps 0..DEPTH-1, one word per cycle. After address DEPTH-1, go to READ.
- READ: ram_rd_en=1; ram_rd_addr steps 0..DEPTH-1. After address DEPTH-1, go to DRAIN.
- DRAIN: one cycle, covering the last read's latency. Then go to FIN.
- FIN: done=1, pass is registered, busy drops. Next state is IDLE.
- RAM read is synchronous: ram_rd_data for the address issued in cycle t is valid in cycle t+1.
- Expected value and address are pipelined one cycle alongside the read and compared in cycle t+1.
- Each mismatch increments err_cnt. The first mismatch of a run also loads first_err_addr.
- Patterns, where a is the address zero-extended to DATA_W and all arithmetic is mod 2^DATA_W:
  - mode 0: seed + a.
  - mode 1: ~(seed + a).
  - mode 2: seed rotated left by (a mod DATA_W).
  - mode 3: as mode 0, except the word written at address 0 has bit 0 inverted. The compare still expects the mode-0 value, so exactly 1 error results.
- Write and read phases never overlap, so no read-during-write behaviour is required.
- RAM contents are not cleared by reset.

## Timing
- Reset values: busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, ram_wr_en=0, ram_rd_en=0, ram_wr_addr=0, ram_rd_addr=0, ram_wr_data=0, state=IDLE. ram_rd_data is RAM output and not reset.
- Start sampled in cycle 0:
  - Writes occur in cycles 1..DEPTH.
  - Reads occur in cycles DEPTH+1..2*DEPTH.
  - Compares occur in cycles DEPTH+2..2*DEPTH+1; DRAIN is cycle 2*DEPTH+1.
  - done=1 and busy=0 in cycle 2*DEPTH+2. Total latency from start to done is 2*DEPTH+2.
- start asserted in the FIN cycle is ignored. A new run may start from the cycle after done.
- sys_rst during a run aborts it immediately: all outputs return to reset values and no done pulse is issued.
- Address counters never wrap past DEPTH-1 when DEPTH < 2^ADDR_W. When DEPTH = 2^ADDR_W, the terminal count is all-ones and the counter must not alias to 0.

## Test plan
- Defaults, mode 0, seed 8'h00: 32 writes with data 0..31, 32 reads. done pulses in cycle 66. pass=1, err_cnt=0, first_err_addr=0.
- Mode 3, seed 8'h10: exactly one error. err_cnt=1, first_err_addr=0, pass=0. The word read back at address 0 is 8'h11.
- Mode 1, seed 8'hFF, and mode 2, seed 8'h81: pass=1.
  - Mode 1 address 1 writes 8'hFF; address 31 writes 8'hE1.
  - Mode 2 address 1 writes 8'h03.
  - Mode 0, seed 8'hF0: the data wraps, with address 16 writing 8'h00.
- Parameters DATA_W=16, ADDR_W=4, DEPTH=16 (full-depth terminal count), mode 0, seed 16'hFFF8: pass=1, done in cycle 34, address 15 holds 16'h0007.
- sys_rst asserted for 1 cycle in the middle of the READ phase: busy=0 and done=0 immediately, with no done afterwards. A new start then completes with pass=1. A start pulse issued while busy has no effect on timing.
- Error saturation: force the RAM output mismatch via a bench `force` on ram_rd_data over 70000 words (DEPTH=256, repeated runs not accumulating). Within a single DEPTH=256, ADDR_W=8 run, err_cnt reaches 256. A bench-forced err_cnt preload of 16'hFFFF stays at 16'hFFFF.

Source files
------------

// File: rtl/ram_2port_bist.sv
// Self-checking dual-port RAM: fills the RAM with a seeded pattern, reads it back and counts mismatches.
// Latency: done pulses 2*DEPTH+2 cycles after an accepted start; start is ignored while a run is in progress.
module ram_2port_bist #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic [DATA_W-1:0] ram_rd_data
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_FIN} state_t;

    state_t              r_state;
    logic [1:0]          r_mode;
    logic [DATA_W-1:0]   r_seed;
    logic                r_busy, r_done, r_pass, r_err_seen;
    logic [15:0]         r_err_cnt;
    logic [ADDR_W-1:0]   r_first_err_addr;
    logic                r_wr_en, r_rd_en, r_cmp_vld;
    logic [ADDR_W-1:0]   r_wr_addr, r_rd_addr, r_cmp_addr;
    logic [DATA_W-1:0]   r_wr_data, r_rd_data, r_cmp_exp;
    logic [DATA_W-1:0]   r_mem [0:(2**ADDR_W)-1];

    logic                w_mis;
    logic [15:0]         w_err_nxt;

    // Mode 3 regenerates the mode-0 sequence; only the written word differs.
    function automatic logic [DATA_W-1:0] f_pat(input logic [1:0] m, input logic [DATA_W-1:0] s,
                                                 input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0]   v_a;
        logic [2*DATA_W-1:0] v_rot;
        int                  v_sh;
        v_a   = DATA_W'(a);
        v_sh  = int'(a) % DATA_W;
        v_rot = {s, s} << v_sh;
        case (m)
            2'd1:    f_pat = ~(s + v_a);
            2'd2:    f_pat = v_rot[2*DATA_W-1:DATA_W];
            default: f_pat = s + v_a;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] f_wr(input logic [1:0] m, input logic [DATA_W-1:0] s,
                                                input logic [ADDR_W-1:0] a);
        logic v_flip;
        v_flip = (m == 2'd3) && (a == '0);
        f_wr   = f_pat(m, s, a) ^ {{(DATA_W-1){1'b0}}, v_flip};
    endfunction

    assign w_mis     = r_cmp_vld && (r_rd_data != r_cmp_exp);
    assign w_err_nxt = (w_mis && r_err_cnt != 16'hFFFF) ? r_err_cnt + 16'd1 : r_err_cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state          <= S_IDLE;
            r_mode           <= '0;
            r_seed           <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_seen       <= 1'b0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_wr_en          <= 1'b0;
            r_wr_addr        <= '0;
            r_wr_data        <= '0;
            r_rd_en          <= 1'b0;
            r_rd_addr        <= '0;
            r_cmp_vld        <= 1'b0;
            r_cmp_addr       <= '0;
            r_cmp_exp        <= '0;
        end else begin
            r_cmp_vld  <= r_rd_en;
            r_cmp_addr <= r_rd_addr;
            r_cmp_exp  <= f_pat(r_mode, r_seed, r_rd_addr);
            if (w_mis) begin
                r_err_cnt <= w_err_nxt;
                if (!r_err_seen) begin
                    r_err_seen       <= 1'b1;
                    r_first_err_addr <= r_cmp_addr;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode           <= mode;
                        r_seed           <= seed;
                        r_err_cnt        <= '0;
                        r_first_err_addr <= '0;
                        r_err_seen       <= 1'b0;
                        r_pass           <= 1'b0;
                        r_busy           <= 1'b1;
                        r_wr_en          <= 1'b1;
                        r_wr_addr        <= '0;
                        r_wr_data        <= f_wr(mode, seed, '0);
                        r_state          <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_wr_addr == LAST) begin
                        r_wr_en   <= 1'b0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                        r_state   <= S_READ;
                    end else begin
                        r_wr_addr <= r_wr_addr + 1'b1;
                        r_wr_data <= f_wr(r_mode, r_seed, r_wr_addr + 1'b1);
                    end
                end
                S_READ: begin
                    if (r_rd_addr == LAST) begin
                        r_rd_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (w_err_nxt == 16'd0);
                    r_state <= S_FIN;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately left out of reset so contents survive an aborted run.
    always_ff @(posedge sys_clk) begin
        if (r_wr_en)
            r_mem[r_wr_addr] <= r_wr_data;
        if (r_rd_en)
            r_rd_data <= r_mem[r_rd_addr];
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err_addr;
    assign ram_wr_en      = r_wr_en;
    assign ram_wr_addr    = r_wr_addr;
    assign ram_wr_data    = r_wr_data;
    assign ram_rd_en      = r_rd_en;
    assign ram_rd_addr    = r_rd_addr;
    assign ram_rd_data    = r_rd_data;

endmodule

// File: tb/tb_ram_2port_bist.sv
// Bench for ram_2port_bist: three parameterisations driven by directed and random runs, checked against a pattern model.
module tb_ram_2port_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // A: default 8 x 32
    logic        a_start = 1'b0, a_busy, a_done, a_pass, a_wr_en, a_rd_en;
    logic [1:0]  a_mode = '0;
    logic [7:0]  a_seed = '0, a_wr_data, a_rd_data;
    logic [15:0] a_err_cnt;
    logic [4:0]  a_first, a_wr_addr, a_rd_addr;
    logic [7:0]  a_wlog [32];
    logic [7:0]  a_rd0;

    // B: 16 x 16, full-depth address counter
    logic        b_start = 1'b0, b_busy, b_done, b_pass, b_wr_en, b_rd_en;
    logic [1:0]  b_mode = '0;
    logic [15:0] b_seed = '0, b_wr_data, b_rd_data, b_err_cnt;
    logic [3:0]  b_first, b_wr_addr, b_rd_addr;

    // C: 8 x 256 for the long error-count runs
    logic        c_start = 1'b0, c_busy, c_done, c_pass, c_wr_en, c_rd_en;
    logic [1:0]  c_mode = '0;
    logic [7:0]  c_seed = '0, c_wr_data, c_rd_data;
    logic [15:0] c_err_cnt;
    logic [7:0]  c_first, c_wr_addr, c_rd_addr;

    ram_2port_bist dut_a (
        .sys_clk(clk), .sys_rst(rst), .start(a_start), .mode(a_mode), .seed(a_seed),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_cnt(a_err_cnt), .first_err_addr(a_first),
        .ram_wr_en(a_wr_en), .ram_wr_addr(a_wr_addr), .ram_wr_data(a_wr_data),
        .ram_rd_en(a_rd_en), .ram_rd_addr(a_rd_addr), .ram_rd_data(a_rd_data));

    ram_2port_bist #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .start(b_start), .mode(b_mode), .seed(b_seed),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err_cnt), .first_err_addr(b_first),
        .ram_wr_en(b_wr_en), .ram_wr_addr(b_wr_addr), .ram_wr_data(b_wr_data),
        .ram_rd_en(b_rd_en), .ram_rd_addr(b_rd_addr), .ram_rd_data(b_rd_data));

    ram_2port_bist #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut_c (
        .sys_clk(clk), .sys_rst(rst), .start(c_start), .mode(c_mode), .seed(c_seed),
        .busy(c_busy), .done(c_done), .pass(c_pass), .err_cnt(c_err_cnt), .first_err_addr(c_first),
        .ram_wr_en(c_wr_en), .ram_wr_addr(c_wr_addr), .ram_wr_data(c_wr_data),
        .ram_rd_en(c_rd_en), .ram_rd_addr(c_rd_addr), .ram_rd_data(c_rd_data));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected (compare-side) word: mode 3 expects the plain mode-0 sequence.
    function automatic logic [63:0] pat(input int w, input int m, input logic [63:0] s, input int a);
        logic [63:0] mask;
        int r;
        mask = (64'd1 << w) - 64'd1;
        case (m)
            1: pat = ~(s + 64'(a)) & mask;
            2: begin
                r   = a % w;
                pat = ((s << r) | (s >> (w - r))) & mask;
            end
            default: pat = (s + 64'(a)) & mask;
        endcase
    endfunction

    // Word actually written: mode 3 corrupts bit 0 at address 0.
    function automatic logic [63:0] wval(input int w, input int m, input logic [63:0] s, input int a);
        wval = pat(w, m, s, a) ^ ((m == 3 && a == 0) ? 64'd1 : 64'd0);
    endfunction

    task automatic run_a(input logic [1:0] m, input logic [7:0] s, input int abort_cyc, input int extra_start_cyc);
        int nwr, nrd, done_cyc, exp_err, ndone;
        nwr = 0; nrd = 0; done_cyc = -1; exp_err = 0;
        for (int a = 0; a < 32; a++)
            if (wval(8, int'(m), 64'(s), a) != pat(8, int'(m), 64'(s), a)) exp_err++;
        @(negedge clk);
        a_mode = m; a_seed = s; a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0; a_mode = ~m; a_seed = ~s;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            a_start = (cyc == extra_start_cyc);
            if (cyc == abort_cyc) begin
                rst = 1'b1;
                #1;
                chk("abort_busy", 64'(a_busy), 64'd0);
                chk("abort_done", 64'(a_done), 64'd0);
                chk("abort_rd_en", 64'(a_rd_en), 64'd0);
                chk("abort_err_cnt", 64'(a_err_cnt), 64'd0);
                @(negedge clk);
                rst = 1'b0;
                ndone = 0;
                repeat (80) begin
                    @(negedge clk);
                    if (a_done) ndone++;
                end
                chk("abort_no_done", 64'(ndone), 64'd0);
                return;
            end
            chk("busy", 64'(a_busy), 64'(cyc < 66));
            if (a_wr_en) begin
                chk("wr_addr", 64'(a_wr_addr), 64'(nwr));
                chk("wr_cycle", 64'(cyc), 64'(nwr + 1));
                chk("wr_data", 64'(a_wr_data), wval(8, int'(m), 64'(s), nwr));
                if (nwr < 32) a_wlog[nwr] = a_wr_data;
                nwr++;
            end
            if (a_rd_en) begin
                chk("rd_addr", 64'(a_rd_addr), 64'(nrd));
                chk("rd_cycle", 64'(cyc), 64'(33 + nrd));
                nrd++;
            end
            if (cyc >= 34 && cyc <= 65)
                chk("rd_data", 64'(a_rd_data), wval(8, int'(m), 64'(s), cyc - 34));
            if (cyc == 34) a_rd0 = a_rd_data;
            if (a_done) begin
                done_cyc = cyc;
                break;
            end
        end
        chk("done_cycle", 64'(done_cyc), 64'd66);
        chk("n_writes", 64'(nwr), 64'd32);
        chk("n_reads", 64'(nrd), 64'd32);
        chk("err_cnt", 64'(a_err_cnt), 64'(exp_err));
        chk("pass", 64'(a_pass), 64'(exp_err == 0));
        chk("first_err_addr", 64'(a_first), 64'd0);
        @(negedge clk);
        chk("done_pulse_width", 64'(a_done), 64'd0);
        chk("pass_held", 64'(a_pass), 64'(exp_err == 0));
    endtask

    task automatic run_c(input logic [1:0] m, input logic [7:0] s, input int preload_cyc, output int done_cyc);
        done_cyc = -1;
        @(negedge clk);
        c_mode = m; c_seed = s; c_start = 1'b1;
        @(posedge clk);
        #1;
        c_start = 1'b0;
        for (int cyc = 1; cyc <= 700; cyc++) begin
            @(negedge clk);
            if (cyc == preload_cyc) force dut_c.r_err_cnt = 16'hFFFF;
            if (cyc == preload_cyc + 1) release dut_c.r_err_cnt;
            if (c_done) begin
                done_cyc = cyc;
                break;
            end
        end
    endtask

    initial begin
        int dc, nwr;
        logic [15:0] b15;
        logic [7:0]  rs;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_pass", 64'(a_pass), 64'd0);
        chk("rst_err_cnt", 64'(a_err_cnt), 64'd0);
        chk("rst_first", 64'(a_first), 64'd0);
        chk("rst_wr_en", 64'(a_wr_en), 64'd0);
        chk("rst_rd_en", 64'(a_rd_en), 64'd0);
        chk("rst_wr_addr", 64'(a_wr_addr), 64'd0);
        chk("rst_rd_addr", 64'(a_rd_addr), 64'd0);
        chk("rst_wr_data", 64'(a_wr_data), 64'd0);

        run_a(2'd0, 8'h00, 0, 0);
        chk("m0_s00_addr5", 64'(a_wlog[5]), 64'h05);
        run_a(2'd3, 8'h10, 0, 0);
        chk("m3_rd_addr0", 64'(a_rd0), 64'h11);
        chk("m3_err_cnt", 64'(a_err_cnt), 64'd1);
        run_a(2'd1, 8'hFF, 0, 0);
        chk("m1_addr1", 64'(a_wlog[1]), 64'hFF);
        chk("m1_addr31", 64'(a_wlog[31]), 64'hE1);
        run_a(2'd2, 8'h81, 0, 0);
        chk("m2_addr1", 64'(a_wlog[1]), 64'h03);
        run_a(2'd0, 8'hF0, 0, 0);
        chk("m0_wrap_addr16", 64'(a_wlog[16]), 64'h00);

        run_a(2'd3, 8'h10, 40, 0);
        run_a(2'd0, 8'h5A, 0, 10);
        for (int i = 0; i < 4; i++) run_a(2'($urandom_range(3)), 8'($urandom), 0, 0);

        nwr = 0; dc = -1; b15 = '0;
        @(negedge clk);
        b_mode = 2'd0; b_seed = 16'hFFF8; b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (b_wr_en) begin
                chk("b_wr_addr", 64'(b_wr_addr), 64'(nwr));
                chk("b_wr_data", 64'(b_wr_data), wval(16, 0, 64'hFFF8, nwr));
                if (b_wr_addr == 4'd15) b15 = b_wr_data;
                nwr++;
            end
            if (cyc >= 18 && cyc <= 33)
                chk("b_rd_data", 64'(b_rd_data), pat(16, 0, 64'hFFF8, cyc - 18));
            if (b_done) begin
                dc = cyc;
                break;
            end
        end
        chk("b_done_cycle", 64'(dc), 64'd34);
        chk("b_n_writes", 64'(nwr), 64'd16);
        chk("b_addr15", 64'(b15), 64'h0007);
        chk("b_pass", 64'(b_pass), 64'd1);
        chk("b_err_cnt", 64'(b_err_cnt), 64'd0);

        force dut_c.r_rd_data = 8'hFF;
        run_c(2'd2, 8'h00, 0, dc);
        chk("c_done_cycle", 64'(dc), 64'd514);
        chk("c_err_cnt_256", 64'(c_err_cnt), 64'd256);
        chk("c_first", 64'(c_first), 64'd0);
        chk("c_pass_fail", 64'(c_pass), 64'd0);
        run_c(2'd2, 8'h00, 300, dc);
        chk("c_sat_done", 64'(dc), 64'd514);
        chk("c_err_cnt_sat", 64'(c_err_cnt), 64'hFFFF);
        release dut_c.r_rd_data;
        rs = 8'($urandom);
        run_c(2'd1, rs, 0, dc);
        chk("c_clean_done", 64'(dc), 64'd514);
        chk("c_clean_err", 64'(c_err_cnt), 64'd0);
        chk("c_clean_pass", 64'(c_pass), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
